// File: rtl/rob_retire.sv
// rtl/rob_retire.sv - two-wide in-order reorder buffer; retires done head entries and releases old_pd to rename
// Optional ROB_STATS_EN adds retired_cnt / stall_cnt counters.
module rob_retire #(
    parameter int DEPTH  = 16,
    parameter int IDX_W  = 4,
    parameter int PREG_W = 6
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              alloc_v_1,
    input  logic [PREG_W-1:0] pd_1,
    input  logic [PREG_W-1:0] old_pd_1,
    input  logic              has_rd_1,
    input  logic              alloc_v_2,
    input  logic [PREG_W-1:0] pd_2,
    input  logic [PREG_W-1:0] old_pd_2,
    input  logic              has_rd_2,
    output logic              alloc_ready,
    output logic [IDX_W-1:0]  rob_idx_1,
    output logic [IDX_W-1:0]  rob_idx_2,
    input  logic              cmp_v_1,
    input  logic [IDX_W-1:0]  cmp_idx_1,
    input  logic              cmp_v_2,
    input  logic [IDX_W-1:0]  cmp_idx_2,
    output logic              rt_flag_1,
    output logic              rt_flag_2,
    output logic [PREG_W-1:0] fp_i_1,
    output logic [PREG_W-1:0] fp_i_2,
    output logic              retire_v_1,
    output logic              retire_v_2,
`ifdef ROB_STATS_EN
    output logic [31:0]       retired_cnt,
    output logic [31:0]       stall_cnt,
`endif
    output logic              empty
);

    logic [DEPTH-1:0]  valid_q, valid_d, done_q, done_d, has_rd_q, has_rd_d;
    logic [PREG_W-1:0] pd_q [DEPTH];
    logic [PREG_W-1:0] pd_d [DEPTH];
    logic [PREG_W-1:0] old_pd_q [DEPTH];
    logic [PREG_W-1:0] old_pd_d [DEPTH];
    logic [IDX_W-1:0]  head_q, head_d, tail_q, tail_d, head_p1, tail_p1;
    logic [IDX_W:0]    count_q, count_d, n_acc, n_ret;
    logic              retire_v_1_q, retire_v_1_d, retire_v_2_q, retire_v_2_d;
    logic              rt_flag_1_q, rt_flag_1_d, rt_flag_2_q, rt_flag_2_d;
    logic [PREG_W-1:0] fp_i_1_q, fp_i_1_d, fp_i_2_q, fp_i_2_d;
    logic              acc_1, acc_2, ret_1, ret_2;
    logic              unused_pd;

    assign head_p1     = head_q + 1'b1;
    assign tail_p1     = tail_q + 1'b1;
    assign alloc_ready = (count_q <= (IDX_W+1)'(DEPTH - 2));
    assign empty       = (count_q == '0);
    assign rob_idx_1   = tail_q;
    assign rob_idx_2   = tail_p1;

    assign acc_1 = alloc_v_1 & alloc_ready;
    assign acc_2 = acc_1 & alloc_v_2;
    // Head+1 may only leave behind the head, keeping retirement strictly in order.
    assign ret_1 = valid_q[head_q] & done_q[head_q];
    assign ret_2 = ret_1 & valid_q[head_p1] & done_q[head_p1];
    assign n_acc = {{IDX_W{1'b0}}, acc_1} + {{IDX_W{1'b0}}, acc_2};
    assign n_ret = {{IDX_W{1'b0}}, ret_1} + {{IDX_W{1'b0}}, ret_2};

    always_comb begin
        valid_d  = valid_q;
        done_d   = done_q;
        has_rd_d = has_rd_q;
        pd_d     = pd_q;
        old_pd_d = old_pd_q;
        head_d   = head_q + IDX_W'(n_ret);
        tail_d   = tail_q + IDX_W'(n_acc);
        count_d  = count_q + n_acc - n_ret;

        if (cmp_v_1 && valid_q[cmp_idx_1]) done_d[cmp_idx_1] = 1'b1;
        if (cmp_v_2 && valid_q[cmp_idx_2]) done_d[cmp_idx_2] = 1'b1;

        if (ret_1) begin
            valid_d[head_q] = 1'b0;
            done_d[head_q]  = 1'b0;
        end
        if (ret_2) begin
            valid_d[head_p1] = 1'b0;
            done_d[head_p1]  = 1'b0;
        end

        // Alloc slots are never live (count <= DEPTH-2), so they cannot collide with retiring entries.
        if (acc_1) begin
            valid_d[tail_q]  = 1'b1;
            done_d[tail_q]   = 1'b0;
            has_rd_d[tail_q] = has_rd_1;
            pd_d[tail_q]     = pd_1;
            old_pd_d[tail_q] = old_pd_1;
        end
        if (acc_2) begin
            valid_d[tail_p1]  = 1'b1;
            done_d[tail_p1]   = 1'b0;
            has_rd_d[tail_p1] = has_rd_2;
            pd_d[tail_p1]     = pd_2;
            old_pd_d[tail_p1] = old_pd_2;
        end

        retire_v_1_d = ret_1;
        retire_v_2_d = ret_2;
        rt_flag_1_d  = ret_1 & has_rd_q[head_q];
        rt_flag_2_d  = ret_2 & has_rd_q[head_p1];
        fp_i_1_d     = rt_flag_1_d ? old_pd_q[head_q]  : '0;
        fp_i_2_d     = rt_flag_2_d ? old_pd_q[head_p1] : '0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q      <= '0;
            done_q       <= '0;
            has_rd_q     <= '0;
            head_q       <= '0;
            tail_q       <= '0;
            count_q      <= '0;
            retire_v_1_q <= 1'b0;
            retire_v_2_q <= 1'b0;
            rt_flag_1_q  <= 1'b0;
            rt_flag_2_q  <= 1'b0;
            fp_i_1_q     <= '0;
            fp_i_2_q     <= '0;
        end else begin
            valid_q      <= valid_d;
            done_q       <= done_d;
            has_rd_q     <= has_rd_d;
            head_q       <= head_d;
            tail_q       <= tail_d;
            count_q      <= count_d;
            retire_v_1_q <= retire_v_1_d;
            retire_v_2_q <= retire_v_2_d;
            rt_flag_1_q  <= rt_flag_1_d;
            rt_flag_2_q  <= rt_flag_2_d;
            fp_i_1_q     <= fp_i_1_d;
            fp_i_2_q     <= fp_i_2_d;
        end
    end

    // Payload is qualified by valid_q, so it needs no reset.
    always_ff @(posedge clk) begin
        pd_q     <= pd_d;
        old_pd_q <= old_pd_d;
    end

    // pd is held per entry for recovery/debug hooks; retire itself only consumes old_pd.
    always_comb begin
        unused_pd = 1'b0;
        for (int i = 0; i < DEPTH; i++) unused_pd = unused_pd ^ (^pd_q[i]);
    end

    assign retire_v_1 = retire_v_1_q;
    assign retire_v_2 = retire_v_2_q;
    assign rt_flag_1  = rt_flag_1_q;
    assign rt_flag_2  = rt_flag_2_q;
    assign fp_i_1     = fp_i_1_q;
    assign fp_i_2     = fp_i_2_q;

`ifdef ROB_STATS_EN
    logic [31:0] retired_cnt_q, retired_cnt_d, stall_cnt_q, stall_cnt_d;

    always_comb begin
        retired_cnt_d = retired_cnt_q + 32'(retire_v_1_q) + 32'(retire_v_2_q);
        stall_cnt_d   = stall_cnt_q + 32'(alloc_v_1 & ~alloc_ready);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            retired_cnt_q <= '0;
            stall_cnt_q   <= '0;
        end else begin
            retired_cnt_q <= retired_cnt_d;
            stall_cnt_q   <= stall_cnt_d;
        end
    end

    assign retired_cnt = retired_cnt_q;
    assign stall_cnt   = stall_cnt_q;
`endif

endmodule
